uart_cmd_parser: RTL and testbench

- Consumes the byte stream produced by the UART receiver (rx_data / rx_done) and assembles short ASCII command lines terminated by CR or LF.
- Decodes each line into single-cycle control pulses for the stopwatch, DHT11 and SR04 blocks, plus a held mode-select value.
- Sits directly downstream of the UART RX stage and upstream of the top-level control mux.

---
 rtl/uart_cmd_parser.sv | 201 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// UART command-line parser: buffers CR/LF-terminated ASCII lines and decodes them into control
// pulses. Define UART_ECHO_EN to echo every received byte on tx_data/tx_start.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN     = 4,
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_run,
  output logic       cmd_clr,
  output logic       cmd_temp,
  output logic       cmd_dist,
  output logic       cmd_mode,
  output logic [1:0] mode_sel,
  output logic       cmd_err,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StDiscard, StExec} state_e;

  state_e                  state_q, state_d;
  logic [LenW-1:0]         len_q, len_d;
  logic [MAX_LEN-1:0][7:0] buf_q, buf_d;
  logic [31:0]             tmo_q, tmo_d;
  logic                    run_q, run_d, clr_q, clr_d, temp_q, temp_d;
  logic                    dist_q, dist_d, mode_q, mode_d, err_q, err_d;
  logic [1:0]              sel_q, sel_d;

  logic       is_term;
  logic [7:0] rx_up;
  logic       tmo_hit;

  always_comb begin
    is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    rx_up   = (rx_data >= 8'h61 && rx_data <= 8'h7A) ? rx_data - 8'h20 : rx_data;
    // A byte arriving in the deciding cycle rescues the line.
    tmo_hit = (TIMEOUT_CYC != 0) && !rx_done && (tmo_q == TIMEOUT_CYC - 1);

    state_d = state_q;
    len_d   = len_q;
    buf_d   = buf_q;
    tmo_d   = tmo_q;
    sel_d   = sel_q;
    run_d   = 1'b0;
    clr_d   = 1'b0;
    temp_d  = 1'b0;
    dist_d  = 1'b0;
    mode_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (rx_done && !is_term) begin
          buf_d[0] = rx_up;
          len_d    = LenW'(1);
          state_d  = StRecv;
        end
      end
      StRecv: begin
        if (rx_done) begin
          tmo_d = '0;
          if (is_term) begin
            state_d = StExec;
          end else if (len_q == LenW'(MAX_LEN)) begin
            state_d = StDiscard;
          end else begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
              if (len_q == LenW'(i)) buf_d[i] = rx_up;
            end
            len_d = len_q + 1'b1;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
          len_d   = '0;
          tmo_d   = '0;
        end else if (TIMEOUT_CYC != 0) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StDiscard: begin
        if (rx_done) begin
          tmo_d = '0;
          if (is_term) begin
            err_d   = 1'b1;
            state_d = StIdle;
            len_d   = '0;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = StIdle;
          len_d   = '0;
          tmo_d   = '0;
        end else if (TIMEOUT_CYC != 0) begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      StExec: begin
        if (len_q == LenW'(1)) begin
          case (buf_q[0])
            8'h52:   run_d  = 1'b1;
            8'h43:   clr_d  = 1'b1;
            8'h54:   temp_d = 1'b1;
            8'h44:   dist_d = 1'b1;
            default: err_d  = 1'b1;
          endcase
        end else if (len_q == LenW'(2) && buf_q[0] == 8'h4D &&
                     buf_q[1] >= 8'h30 && buf_q[1] <= 8'h33) begin
          sel_d  = buf_q[1][1:0];
          mode_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = StIdle;
        len_d   = '0;
        tmo_d   = '0;
        // A byte landing in the decode cycle opens the next line immediately.
        if (rx_done && !is_term) begin
          buf_d[0] = rx_up;
          len_d    = LenW'(1);
          state_d  = StRecv;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      buf_q   <= '0;
      tmo_q   <= '0;
      sel_q   <= 2'd0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      temp_q  <= 1'b0;
      dist_q  <= 1'b0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      buf_q   <= buf_d;
      tmo_q   <= tmo_d;
      sel_q   <= sel_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
      temp_q  <= temp_d;
      dist_q  <= dist_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign cmd_run  = run_q;
  assign cmd_clr  = clr_q;
  assign cmd_temp = temp_q;
  assign cmd_dist = dist_q;
  assign cmd_mode = mode_q;
  assign cmd_err  = err_q;
  assign mode_sel = sel_q;
  assign busy     = (state_q != StIdle);

`ifdef UART_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;

  always_comb begin
    tx_start_d = rx_done && !tx_busy;
    tx_data_d  = tx_start_d ? rx_data : tx_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_data        = '0;
  assign tx_start       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus a randomized byte stream,
// scored against a line-level reference model that predicts every pulse and its cycle.
module tb_uart_cmd_parser;

  localparam int MaxLen = 4;
  localparam int TmoCyc = 50;
  localparam int KRun = 0, KClr = 1, KTemp = 2, KDist = 3, KMode = 4, KErr = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic       cmd_run, cmd_clr, cmd_temp, cmd_dist, cmd_mode, cmd_err, busy, tx_start;
  logic [1:0] mode_sel;
  logic [7:0] tx_data;

  uart_cmd_parser #(
    .MAX_LEN     (MaxLen),
    .TIMEOUT_CYC (TmoCyc)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .cmd_run  (cmd_run),
    .cmd_clr  (cmd_clr),
    .cmd_temp (cmd_temp),
    .cmd_dist (cmd_dist),
    .cmd_mode (cmd_mode),
    .mode_sel (mode_sel),
    .cmd_err  (cmd_err),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Events encoded as cycle*8 + kind.
  int         ev_q[$];
  int         exp_q[$];
  logic [7:0] line_q[$];
  int         last_cyc = 0;
  logic [1:0] exp_mode = 2'd0;
  int         n_checks = 0;
  int         n_pass = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (cmd_run)  ev_q.push_back(cyc * 8 + KRun);
      if (cmd_clr)  ev_q.push_back(cyc * 8 + KClr);
      if (cmd_temp) ev_q.push_back(cyc * 8 + KTemp);
      if (cmd_dist) ev_q.push_back(cyc * 8 + KDist);
      if (cmd_mode) ev_q.push_back(cyc * 8 + KMode);
      if (cmd_err)  ev_q.push_back(cyc * 8 + KErr);
    end
  end

  // Abandon an open line whose last byte is more than TmoCyc cycles before `now`.
  function automatic void model_advance(input int now);
    if (line_q.size() > 0 && now > last_cyc + TmoCyc) begin
      exp_q.push_back((last_cyc + TmoCyc + 1) * 8 + KErr);
      line_q.delete();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int c);
    int k;
    model_advance(c);
    if (b == 8'h0D || b == 8'h0A) begin
      if (line_q.size() > MaxLen) begin
        exp_q.push_back((c + 1) * 8 + KErr);
      end else if (line_q.size() != 0) begin
        k = KErr;
        if (line_q.size() == 1) begin
          if (line_q[0] == "R") k = KRun;
          if (line_q[0] == "C") k = KClr;
          if (line_q[0] == "T") k = KTemp;
          if (line_q[0] == "D") k = KDist;
        end else if (line_q.size() == 2 && line_q[0] == "M" &&
                     line_q[1] >= "0" && line_q[1] <= "3") begin
          k        = KMode;
          exp_mode = 2'(line_q[1] - 8'h30);
        end
        exp_q.push_back((c + 2) * 8 + k);
      end
      line_q.delete();
    end else begin
      line_q.push_back((b >= "a" && b <= "z") ? b - 8'h20 : b);
    end
    last_cyc = c;
  endfunction

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, cyc);
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle(3);
    n_checks++;
    if ({cmd_run, cmd_clr, cmd_temp, cmd_dist, cmd_mode, cmd_err, busy} !== 7'd0)
      $display("FAIL reset_pulses: got %b, expected 0000000",
               {cmd_run, cmd_clr, cmd_temp, cmd_dist, cmd_mode, cmd_err, busy});
    else n_pass++;
    n_checks++;
    if ({mode_sel, tx_data, tx_start} !== 11'd0)
      $display("FAIL reset_sel_tx: got mode_sel=%0d tx_data=%h tx_start=%b, expected 0/00/0",
               mode_sel, tx_data, tx_start);
    else n_pass++;
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_run;
    ev_q.delete(); exp_q.delete();
    send("R"); send(8'h0D); idle(6);
    n_checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL run_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL run_ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i,
                 ev_q[i] / 8, ev_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
      else n_pass++;
    end
  endtask

  task automatic test_mode;
    ev_q.delete(); exp_q.delete();
    send("m"); send("2"); send(8'h0A); idle(4);
    n_checks++;
    if (mode_sel !== 2'd2) $display("FAIL mode_set: got %0d, expected 2", mode_sel);
    else n_pass++;
    send("M"); send("7"); send(8'h0A); idle(4);
    n_checks++;
    if (mode_sel !== 2'd2) $display("FAIL mode_hold: got %0d, expected 2", mode_sel);
    else n_pass++;
    n_checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL mode_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL mode_ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i,
                 ev_q[i] / 8, ev_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
      else n_pass++;
    end
  endtask

  task automatic test_overflow;
    ev_q.delete(); exp_q.delete();
    send("A"); send("B"); send("C"); send("D"); send("E"); send(8'h0D); idle(3);
    send("C"); send(8'h0D); idle(4);
    n_checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL ovf_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL ovf_ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i,
                 ev_q[i] / 8, ev_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    int tb;
    ev_q.delete(); exp_q.delete();
    tb = cyc;
    send("T");
    while (cyc < tb + TmoCyc) idle(1);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL tmo_busy_before: got %b, expected 1", busy);
    else n_pass++;
    idle(1);
    n_checks++;
    if ({busy, cmd_err} !== 2'b01)
      $display("FAIL tmo_fire: got busy=%b cmd_err=%b, expected busy=0 cmd_err=1", busy, cmd_err);
    else n_pass++;
    idle(5);
    send(8'h0D); idle(5);
    n_checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL tmo_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL tmo_ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i,
                 ev_q[i] / 8, ev_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    ev_q.delete(); exp_q.delete();
    send("D"); send(8'h0D); send("R"); send(8'h0D); idle(5);
    n_checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL b2b_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL b2b_ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i,
                 ev_q[i] / 8, ev_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
      else n_pass++;
    end
    send("M"); send("1");
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cmd_run, cmd_clr, cmd_temp, cmd_dist, cmd_mode, cmd_err, busy, mode_sel} !== 9'd0)
      $display("FAIL midline_reset: got %b, expected 000000000",
               {cmd_run, cmd_clr, cmd_temp, cmd_dist, cmd_mode, cmd_err, busy, mode_sel});
    else n_pass++;
    line_q.delete();
    exp_mode = 2'd0;
    idle(2);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_echo;
    ev_q.delete(); exp_q.delete();
`ifdef UART_ECHO_EN
    tx_busy = 1'b0;
    send("x");
    n_checks++;
    if ({tx_start, tx_data} !== {1'b1, 8'h78})
      $display("FAIL echo_x: got tx_start=%b tx_data=%h, expected 1/78", tx_start, tx_data);
    else n_pass++;
    idle(1);
    n_checks++;
    if (tx_start !== 1'b0) $display("FAIL echo_x_len: got tx_start=%b, expected 0", tx_start);
    else n_pass++;
    tx_busy = 1'b1;
    send("y");
    n_checks++;
    if (tx_start !== 1'b0) $display("FAIL echo_drop: got tx_start=%b, expected 0", tx_start);
    else n_pass++;
    tx_busy = 1'b0;
`else
    send("x");
    n_checks++;
    if ({tx_start, tx_data} !== 9'd0)
      $display("FAIL no_echo: got tx_start=%b tx_data=%h, expected 0/00", tx_start, tx_data);
    else n_pass++;
    send("y");
`endif
    send(8'h0D); idle(4);
    n_checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL echo_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL echo_ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i,
                 ev_q[i] / 8, ev_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [7:0] pool[16];
    int         gap;
    pool = '{"R", "r", "C", "c", "T", "D", "d", "M", "m", "0", "2", "3", "7", "Q",
             8'h0D, 8'h0A};
    ev_q.delete(); exp_q.delete();
    for (int n = 0; n < 120; n++) begin
      send(pool[$urandom_range(0, 15)]);
      if ($urandom_range(0, 9) == 0) gap = int'($urandom_range(45, 55));
      else gap = int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
    end
    send(8'h0D);
    idle(TmoCyc + 5);
    model_advance(cyc);
    n_checks++;
    if (mode_sel !== exp_mode)
      $display("FAIL rnd_mode_sel: got %0d, expected %0d", mode_sel, exp_mode);
    else n_pass++;
    n_checks++;
    if (ev_q.size() !== exp_q.size())
      $display("FAIL rnd_count: got %0d events, expected %0d", ev_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (ev_q[i] !== exp_q[i])
        $display("FAIL rnd_ev%0d: got cyc %0d kind %0d, expected cyc %0d kind %0d", i,
                 ev_q[i] / 8, ev_q[i] % 8, exp_q[i] / 8, exp_q[i] % 8);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_mode();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_echo();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
